// File: rtl/branch_resolve_pc_if.sv
// EX-stage branch resolution bus: execute-stage instruction info and comparator
// results in, fetch PC / redirect / flush / statistics out.
interface branch_resolve_pc_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall_i;
    logic             ex_valid_i;
    logic             ex_br_i;
    logic             ex_jal_i;
    logic             ex_jalr_i;
    logic [2:0]       ex_funct3_i;
    logic [31:0]      ex_target_i;
    logic             br_less_i;
    logic             br_equal_i;
    logic             br_unsigned_o;
    logic [31:0]      pc_o;
    logic             redirect_o;
    logic             flush_o;
    logic             misalign_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] br_taken_cnt_o;

    // Pipeline / comparator side: drives EX info, observes PC control.
    modport master (
        output stall_i, ex_valid_i, ex_br_i, ex_jal_i, ex_jalr_i, ex_funct3_i,
               ex_target_i, br_less_i, br_equal_i,
        input  br_unsigned_o, pc_o, redirect_o, flush_o, misalign_o, br_cnt_o,
               br_taken_cnt_o
    );

    // Branch resolution unit side.
    modport slave (
        input  stall_i, ex_valid_i, ex_br_i, ex_jal_i, ex_jalr_i, ex_funct3_i,
               ex_target_i, br_less_i, br_equal_i,
        output br_unsigned_o, pc_o, redirect_o, flush_o, misalign_o, br_cnt_o,
               br_taken_cnt_o
    );
endinterface

// File: rtl/branch_resolve_pc.sv
// Execute-stage branch resolution and fetch PC generation for the RV32I core.
// Resolves B-type/JAL/JALR, owns the PC register, issues redirect plus a timed
// flush of younger instructions, and keeps saturating branch statistics.
module branch_resolve_pc #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic                clk_i,
    input logic                rst_ni,
    branch_resolve_pc_if.slave bus
);
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    logic [31:0]      r_pc;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic             r_misalign;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [31:0]      w_pc_d;
    logic [FLUSH_W-1:0] w_flush_cnt_d;
    logic [CNT_W-1:0] w_br_cnt_d;
    logic [CNT_W-1:0] w_taken_cnt_d;
    logic             w_flush;
    logic             w_eff_valid;
    logic             w_cond;
    logic [31:0]      w_tgt;
    logic             w_take;
    logic             w_mis;
    logic             w_redirect;
    logic             w_br_inc;
    logic             w_taken_inc;

    // Instructions in the shadow of a redirect are squashed and must not act.
    assign w_flush     = (r_flush_cnt != '0);
    assign w_eff_valid = bus.ex_valid_i & ~w_flush;

    // Branch condition decode from funct3; reserved encodings never take.
    always_comb begin
        w_cond = 1'b0;
        case (bus.ex_funct3_i)
            3'b000:  w_cond = bus.br_equal_i;
            3'b001:  w_cond = ~bus.br_equal_i;
            3'b100:  w_cond = bus.br_less_i;
            3'b101:  w_cond = ~bus.br_less_i;
            3'b110:  w_cond = bus.br_less_i;
            3'b111:  w_cond = ~bus.br_less_i;
            default: w_cond = 1'b0;
        endcase
    end

    // JALR clears bit 0; anything still not word aligned is reported, not taken.
    assign w_tgt       = {bus.ex_target_i[31:1], bus.ex_target_i[0] & ~bus.ex_jalr_i};
    assign w_take      = w_eff_valid & (bus.ex_jal_i | bus.ex_jalr_i | (bus.ex_br_i & w_cond));
    assign w_mis       = w_take & (w_tgt[1:0] != 2'b00);
    assign w_redirect  = w_take & ~w_mis;
    assign w_br_inc    = w_eff_valid & bus.ex_br_i & ~bus.stall_i;
    assign w_taken_inc = w_br_inc & w_cond;

    // Next PC: redirect wins over stall, otherwise sequential fetch.
    always_comb begin
        w_pc_d = r_pc + 32'd4;
        if (w_redirect) begin
            w_pc_d = w_tgt;
        end else if (bus.stall_i) begin
            w_pc_d = r_pc;
        end
    end

    // Flush window: reload on redirect, count down only while not stalled.
    always_comb begin
        w_flush_cnt_d = r_flush_cnt;
        if (w_redirect) begin
            w_flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
        end else if (w_flush && !bus.stall_i) begin
            w_flush_cnt_d = r_flush_cnt - FLUSH_W'(1);
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_comb begin
        w_br_cnt_d    = r_br_cnt;
        w_taken_cnt_d = r_taken_cnt;
        if (w_br_inc && (r_br_cnt != '1)) begin
            w_br_cnt_d = r_br_cnt + CNT_W'(1);
        end
        if (w_taken_inc && (r_taken_cnt != '1)) begin
            w_taken_cnt_d = r_taken_cnt + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc        <= RESET_PC;
            r_flush_cnt <= '0;
            r_misalign  <= 1'b0;
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_pc        <= w_pc_d;
            r_flush_cnt <= w_flush_cnt_d;
            r_misalign  <= w_mis;
            r_br_cnt    <= w_br_cnt_d;
            r_taken_cnt <= w_taken_cnt_d;
        end
    end

    assign bus.br_unsigned_o  = bus.ex_funct3_i[1];
    assign bus.pc_o           = r_pc;
    assign bus.redirect_o     = w_redirect;
    assign bus.flush_o        = w_flush;
    assign bus.misalign_o     = r_misalign;
    assign bus.br_cnt_o       = r_br_cnt;
    assign bus.br_taken_cnt_o = r_taken_cnt;
endmodule

// File: tb/tb_branch_resolve_pc.sv
// Directed bench for branch_resolve_pc: expected post-edge state is queued
// when a step is driven and popped by a monitor just after the clock edge.
module tb_branch_resolve_pc;
    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    branch_resolve_pc_if #(.CNT_W(16)) bif ();
    branch_resolve_pc_if #(.CNT_W(2))  bif2 ();

    branch_resolve_pc #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bif)
    );

    branch_resolve_pc #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(2)) u_dut_sat (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bif2)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Registered outputs are compared 1 time unit after each rising edge.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, bif.pc_o, e.pc);
            check({e.tag, ".flush"}, 32'(bif.flush_o), 32'(e.flush));
            check({e.tag, ".mis"}, 32'(bif.misalign_o), 32'(e.mis));
            check({e.tag, ".bcnt"}, 32'(bif.br_cnt_o), e.bc);
            check({e.tag, ".tcnt"}, 32'(bif.br_taken_cnt_o), e.tc);
        end
    end

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic stall, input logic [2:0] f3, input logic [31:0] tgt,
                         input logic less, input logic eq);
        bif.ex_valid_i  = v;
        bif.ex_br_i     = br;
        bif.ex_jal_i    = jal;
        bif.ex_jalr_i   = jalr;
        bif.stall_i     = stall;
        bif.ex_funct3_i = f3;
        bif.ex_target_i = tgt;
        bif.br_less_i   = less;
        bif.br_equal_i  = eq;
    endtask

    // Apply one EX cycle: check comb outputs, queue expected state after the edge.
    task automatic step(input string tag, input logic v, input logic br, input logic jal,
                        input logic jalr, input logic stall, input logic [2:0] f3,
                        input logic [31:0] tgt, input logic less, input logic eq,
                        input logic e_redir, input logic e_uns, input logic [31:0] e_pc,
                        input logic e_flush, input logic e_mis, input int e_bc,
                        input int e_tc);
        exp_t e;
        drive(v, br, jal, jalr, stall, f3, tgt, less, eq);
        #1;
        check({tag, ".redirect"}, 32'(bif.redirect_o), 32'(e_redir));
        check({tag, ".unsigned"}, 32'(bif.br_unsigned_o), 32'(e_uns));
        e.tag = tag; e.pc = e_pc; e.flush = e_flush; e.mis = e_mis;
        e.bc = 32'(e_bc); e.tc = 32'(e_tc);
        sb.push_back(e);
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input string tag, input logic stall, input logic [31:0] e_pc,
                        input logic e_flush, input int e_bc, input int e_tc);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, stall, 3'b000, 32'h0, 1'b0, 1'b0,
             1'b0, 1'b0, e_pc, e_flush, 1'b0, e_bc, e_tc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        bif2.stall_i = 1'b0; bif2.ex_valid_i = 1'b0; bif2.ex_br_i = 1'b0;
        bif2.ex_jal_i = 1'b0; bif2.ex_jalr_i = 1'b0; bif2.ex_funct3_i = 3'b000;
        bif2.ex_target_i = 32'h0; bif2.br_less_i = 1'b0; bif2.br_equal_i = 1'b0;
        #1 rst_ni = 1'b0;
        #11;
        check("reset.pc", bif.pc_o, 32'h0);
        check("reset.flush", 32'(bif.flush_o), 32'h0);
        check("reset.mis", 32'(bif.misalign_o), 32'h0);
        check("reset.bcnt", 32'(bif.br_cnt_o), 32'h0);
        check("reset.tcnt", 32'(bif.br_taken_cnt_o), 32'h0);
        rst_ni = 1'b1;

        // Sequential fetch up to pc 0x20.
        for (int i = 1; i <= 8; i++) idle("seq", 1'b0, 32'(4 * i), 1'b0, 0, 0);

        // BEQ taken to 0x100, then a valid branch inside the flush shadow.
        step("beq", 1, 1, 0, 0, 0, 3'b000, 32'h100, 0, 1, 1, 0, 32'h100, 1, 0, 1, 1);
        step("shadow", 1, 1, 0, 0, 0, 3'b000, 32'h300, 0, 1, 0, 0, 32'h104, 1, 0, 1, 1);
        idle("flush_end", 1'b0, 32'h108, 1'b0, 1, 1);

        // BGEU with less=1: unsigned compare, not taken.
        step("bgeu", 1, 1, 0, 0, 0, 3'b111, 32'h400, 1, 0, 0, 1, 32'h10C, 0, 0, 2, 1);

        // JALR to 0x203 -> 0x202 misaligned; JALR to 0x201 -> 0x200.
        step("jalr_mis", 1, 0, 0, 1, 0, 3'b000, 32'h203, 0, 0, 0, 0, 32'h110, 0, 1, 2, 1);
        step("jalr_ok", 1, 0, 0, 1, 0, 3'b000, 32'h201, 0, 0, 1, 0, 32'h200, 1, 0, 2, 1);
        idle("jalr_f1", 1'b0, 32'h204, 1'b1, 2, 1);
        idle("jalr_f2", 1'b0, 32'h208, 1'b0, 2, 1);

        // Stall holds PC; redirect overrides stall; stall freezes flush count.
        idle("stall", 1'b1, 32'h208, 1'b0, 2, 1);
        step("jal_stall", 1, 0, 1, 0, 1, 3'b000, 32'h1000, 0, 0, 1, 0, 32'h1000, 1, 0, 2, 1);
        idle("flush_hold", 1'b1, 32'h1000, 1'b1, 2, 1);
        idle("flush_dec", 1'b0, 32'h1004, 1'b1, 2, 1);

        // Asynchronous reset while flush is still active.
        #1 rst_ni = 1'b0;
        #1;
        check("midrst.pc", bif.pc_o, 32'h0);
        check("midrst.flush", 32'(bif.flush_o), 32'h0);
        check("midrst.bcnt", 32'(bif.br_cnt_o), 32'h0);
        #3 rst_ni = 1'b1;
        idle("post_rst", 1'b0, 32'h4, 1'b0, 0, 0);

        // BLTU taken, reserved funct3 010 never taken.
        step("bltu", 1, 1, 0, 0, 0, 3'b110, 32'h80, 1, 0, 1, 1, 32'h80, 1, 0, 1, 1);
        idle("bltu_f1", 1'b0, 32'h84, 1'b1, 1, 1);
        idle("bltu_f2", 1'b0, 32'h88, 1'b0, 1, 1);
        step("f3_010", 1, 1, 0, 0, 0, 3'b010, 32'h500, 1, 1, 0, 1, 32'h8C, 0, 0, 2, 1);

        // BNE taken, JAL to top of memory and PC wrap-around.
        step("bne", 1, 1, 0, 0, 0, 3'b001, 32'h40, 0, 0, 1, 0, 32'h40, 1, 0, 3, 2);
        idle("bne_f1", 1'b0, 32'h44, 1'b1, 3, 2);
        idle("bne_f2", 1'b0, 32'h48, 1'b0, 3, 2);
        step("jal_top", 1, 0, 1, 0, 0, 3'b000, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'hFFFF_FFFC,
             1, 0, 3, 2);
        idle("wrap", 1'b0, 32'h0, 1'b1, 3, 2);
        idle("wrap2", 1'b0, 32'h4, 1'b0, 3, 2);

        // 2-bit counters saturate at 3 over five taken branches.
        for (int k = 1; k <= 5; k++) begin
            bif2.ex_valid_i = 1'b1; bif2.ex_br_i = 1'b1; bif2.ex_funct3_i = 3'b000;
            bif2.br_equal_i = 1'b1; bif2.ex_target_i = 32'h40;
            @(posedge clk_i);
            #1;
            bif2.ex_valid_i = 1'b0; bif2.ex_br_i = 1'b0; bif2.br_equal_i = 1'b0;
            check($sformatf("sat%0d.bcnt", k), 32'(bif2.br_cnt_o), (k > 3) ? 32'd3 : 32'(k));
            check($sformatf("sat%0d.tcnt", k), 32'(bif2.br_taken_cnt_o),
                  (k > 3) ? 32'd3 : 32'(k));
            @(posedge clk_i);
            @(posedge clk_i);
            #1;
        end

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
